ble_lutk_cfg: RTL

- Parametrised basic logic element: K-input LUT, one flip-flop, and a 2:1 output select.
- Configuration memory is addressable, written one bit per cycle through enable/address/data_in, and readable back.
- Adds clock-enable, a configurable FF set value, and readback, none of which the fixed 4-LUT BLE has.
- Instantiated K-generic inside the fle/clb logical tiles.

---
 rtl/ble_pkg.sv | 19 +
 rtl/ble_cfg_mem.sv | 37 +++
 rtl/ble_lutk_cfg.sv | 69 ++++++
 3 files changed

// File: rtl/ble_pkg.sv
// Shared constants and sizing helpers for the K-input configurable BLE.
package ble_pkg;

  // Control-bit offsets, relative to the end of the truth table.
  localparam int unsigned OFF_OUT_SEL = 0;
  localparam int unsigned OFF_SET_VAL = 1;
  localparam int unsigned OFF_USE_CE  = 2;

  // Total configuration bits for a K-input LUT: truth table plus three control bits.
  function automatic int unsigned cfg_bits(input int unsigned k);
    return (32'd1 << k) + 32'd3;
  endfunction

  // Width of an address that spans every configuration bit.
  function automatic int unsigned cfg_addr_w(input int unsigned k);
    return $clog2(cfg_bits(k));
  endfunction

endpackage

// File: rtl/ble_cfg_mem.sv
// Bit-addressable configuration memory with single-bit writes and registered readback.
module ble_cfg_mem #(
  parameter int unsigned CFG_BITS = 19,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   address,
  input  logic                data_in,
  output logic                cfg_rdata,
  output logic [CFG_BITS-1:0] cfg
);

  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(CFG_BITS);

  logic in_range;

  // Addresses past the last configuration bit are neither writable nor readable.
  always_comb begin
    in_range = ({1'b0, address} < ADDR_LIM);
  end

  // Write decode and readback; readback sees the pre-write value during a same-address write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg       <= '0;
      cfg_rdata <= 1'b0;
    end else begin
      if (enable && in_range) begin
        cfg[address] <= data_in;
      end
      cfg_rdata <= in_range ? cfg[address] : 1'b0;
    end
  end

endmodule

// File: rtl/ble_lutk_cfg.sv
// K-input LUT basic logic element with one flip-flop, clock-enable, configurable
// set value, output select, and bit-addressable configuration with readback.
module ble_lutk_cfg
  import ble_pkg::*;
#(
  parameter int unsigned K        = 4,
  parameter int unsigned LUT_BITS = 2 ** K,
  parameter int unsigned CFG_BITS = cfg_bits(K),
  parameter int unsigned ADDR_W   = cfg_addr_w(K)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic [K-1:0]      ble_in,
  input  logic              ble_ce,
  input  logic              enable,
  input  logic [ADDR_W-1:0] address,
  input  logic              data_in,
  output logic              cfg_rdata,
  output logic              ble_out
);

  logic [CFG_BITS-1:0] cfg;
  logic [LUT_BITS-1:0] truth;
  logic                lut_out;
  logic                out_sel;
  logic                set_val;
  logic                use_ce;
  logic                q;

  ble_cfg_mem #(
    .CFG_BITS (CFG_BITS),
    .ADDR_W   (ADDR_W)
  ) u_cfg_mem (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .address   (address),
    .data_in   (data_in),
    .cfg_rdata (cfg_rdata),
    .cfg       (cfg)
  );

  // Split the configuration vector into truth table and control fields; LUT lookup.
  always_comb begin
    truth   = cfg[LUT_BITS-1:0];
    out_sel = cfg[LUT_BITS + OFF_OUT_SEL];
    set_val = cfg[LUT_BITS + OFF_SET_VAL];
    use_ce  = cfg[LUT_BITS + OFF_USE_CE];
    lut_out = truth[ble_in];
  end

  // Flip-flop: reset beats set, set beats clock-enable hold, otherwise capture the LUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (set) begin
      q <= set_val;
    end else if (!(use_ce && !ble_ce)) begin
      q <= lut_out;
    end
  end

  // Output select between the registered and combinational paths.
  always_comb begin
    ble_out = out_sel ? q : lut_out;
  end

endmodule
